bcd_seq_ctrl: RTL and testbench



---
 rtl/bcd_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_bcd_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_ctrl.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one shift per clock.
// Ports: clk, rst_n (sync, active-low), start/bin in; busy, done, bcd, overflow out.
// Optional macro BCD_SEQ_BLANK_EN adds output blank (leading-zero digit mask).
module bcd_seq_ctrl #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
`ifdef BCD_SEQ_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int AW = 4 * DIGITS;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [BIN_W-1:0] r_sreg;
  logic [BIN_W-1:0] w_sreg_n;
  logic [AW-1:0]    r_acc;
  logic [AW-1:0]    w_acc_n;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_n;
  logic             r_ovf;
  logic             w_ovf_n;
  logic [AW-1:0]    r_bcd;
  logic [AW-1:0]    w_bcd_n;
  logic             r_ovf_out;
  logic             w_ovf_out_n;
  logic             r_done;
  logic             w_done_n;

  logic [AW-1:0]    w_adj;
  logic [AW-1:0]    w_shift;
  logic             w_ovf_step;
  logic             w_last;

  // Per-digit +3 correction; digits never carry into each other.
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // A set MSB after correction is lost by the shift: result too wide.
  assign w_shift    = {w_adj[AW-2:0], r_sreg[BIN_W-1]};
  assign w_ovf_step = w_adj[AW-1];
  assign w_last     = (r_cnt == CNT_W'(BIN_W - 1));

  always_comb begin
    w_state_n   = r_state;
    w_sreg_n    = r_sreg;
    w_acc_n     = r_acc;
    w_cnt_n     = r_cnt;
    w_ovf_n     = r_ovf;
    w_bcd_n     = r_bcd;
    w_ovf_out_n = r_ovf_out;
    w_done_n    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_sreg_n  = bin;
          w_acc_n   = '0;
          w_ovf_n   = 1'b0;
          w_cnt_n   = '0;
          w_state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_sreg_n = {r_sreg[BIN_W-2:0], 1'b0};
        w_acc_n  = w_shift;
        w_ovf_n  = r_ovf | w_ovf_step;
        w_cnt_n  = r_cnt + CNT_W'(1);
        if (w_last) begin
          w_bcd_n     = w_shift;
          w_ovf_out_n = r_ovf | w_ovf_step;
          w_done_n    = 1'b1;
          w_state_n   = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sreg    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_bcd     <= '0;
      r_ovf_out <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_sreg    <= w_sreg_n;
      r_acc     <= w_acc_n;
      r_cnt     <= w_cnt_n;
      r_ovf     <= w_ovf_n;
      r_bcd     <= w_bcd_n;
      r_ovf_out <= w_ovf_out_n;
      r_done    <= w_done_n;
    end
  end

  assign busy     = (r_state == S_SHIFT);
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_ovf_out;

`ifdef BCD_SEQ_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank;
  logic              w_hi_zero;

  // Digit i is blank when it and every digit above it are zero.
  always_comb begin
    w_blank   = '0;
    w_hi_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_hi_zero  = w_hi_zero && (w_shift[4*i +: 4] == 4'd0);
      w_blank[i] = w_hi_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blank <= '0;
    end else if (r_state == S_SHIFT && w_last) begin
      r_blank <= w_blank;
    end
  end

  assign blank = r_blank;
`endif

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Scoreboard bench for bcd_seq_ctrl: default 5-digit instance plus a
// 4-digit instance for overflow cases.
module tb_bcd_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin = '0;
  logic        busy, done, overflow;
  logic [19:0] bcd;

  logic        start4 = 1'b0;
  logic [15:0] bin4 = '0;
  logic        busy4, done4, overflow4;
  logic [15:0] bcd4;

`ifdef BCD_SEQ_BLANK_EN
  logic [4:0]  blank;
  logic [3:0]  blank4;
`endif

  always #5 clk = ~clk;

  bcd_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
`ifdef BCD_SEQ_BLANK_EN
    ,
    .blank    (blank)
`endif
  );

  bcd_seq_ctrl #(.BIN_W(16), .DIGITS(4), .CNT_W(5)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start4),
    .bin      (bin4),
    .busy     (busy4),
    .done     (done4),
    .bcd      (bcd4),
    .overflow (overflow4)
`ifdef BCD_SEQ_BLANK_EN
    ,
    .blank    (blank4)
`endif
  );

  typedef struct {
    logic [19:0] bcd;
    logic        ovf;
    logic [4:0]  blank;
  } exp_t;

  exp_t q[$];
  exp_t q4[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [19:0] b, input logic o,
                      input logic [4:0] bl);
    exp_t e;
    e.bcd = b; e.ovf = o; e.blank = bl;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done: got bcd %0h expected none", bcd);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("bcd", 32'(bcd), 32'(e.bcd));
        chk("overflow", 32'(overflow), 32'(e.ovf));
`ifdef BCD_SEQ_BLANK_EN
        chk("blank", 32'(blank), 32'(e.blank));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done4: got bcd %0h expected none", bcd4);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("bcd4", 32'(bcd4), 32'(e.bcd[15:0]));
        chk("overflow4", 32'(overflow4), 32'(e.ovf));
`ifdef BCD_SEQ_BLANK_EN
        chk("blank4", 32'(blank4), 32'(e.blank[3:0]));
`endif
      end
    end
  end

  // Called at the negedge after the accepting edge; returns negedges
  // waited until done and the number of those with busy high.
  task automatic wait_done(output int cyc, output int nb);
    cyc = 0; nb = 0;
    while (!done && cyc < 40) begin
      if (busy) nb++;
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: got no done expected done within 40");
    end
  endtask

  task automatic conv(input logic [15:0] b, input logic [19:0] eb,
                      input logic [4:0] ebl);
    int c, nb;
    @(negedge clk);
    start = 1'b1; bin = b;
    push(eb, 1'b0, ebl);
    @(negedge clk);
    start = 1'b0; bin = 16'hDEAD;
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done(c, nb);
    chk("latency", 32'(c), 32'd16);
    chk("busy_cycles", 32'(nb), 32'd16);
    chk("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic conv4(input logic [15:0] b, input logic [15:0] eb,
                       input logic eo, input logic [3:0] ebl);
    exp_t e;
    int c;
    @(negedge clk);
    start4 = 1'b1; bin4 = b;
    e.bcd = {4'd0, eb}; e.ovf = eo; e.blank = {1'b0, ebl};
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
    c = 0;
    while (!done4 && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("latency4", 32'(c), 32'd16);
  endtask

  initial begin
    int c, nb;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_bcd4", 32'(bcd4), 32'd0);
    rst_n = 1'b1;

    conv(16'hFFFF, 20'h65535, 5'b00000);

    // Back-to-back: start held through the done cycle.
    @(negedge clk);
    start = 1'b1; bin = 16'd0;
    push(20'h00000, 1'b0, 5'b11110);
    @(negedge clk);
    bin = 16'd9999;
    push(20'h09999, 1'b0, 5'b10000);
    wait_done(c, nb);
    chk("b2b_lat1", 32'(c), 32'd16);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_restart", 32'(busy), 32'd1);
    wait_done(c, nb);
    chk("b2b_lat2", 32'(c), 32'd16);
    chk("b2b_busy2", 32'(nb), 32'd16);

    // Starts during busy are ignored.
    @(negedge clk);
    start = 1'b1; bin = 16'd1234;
    push(20'h01234, 1'b0, 5'b10000);
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!done && c < 40) begin
      start = (c == 3 || c == 10);
      bin = start ? 16'd7777 : 16'd0;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk("ign_latency", 32'(c), 32'd16);
    repeat (20) @(negedge clk);
    chk("ign_idle", 32'(busy), 32'd0);

    // Reset mid-conversion.
    @(negedge clk);
    start = 1'b1; bin = 16'd4321;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (20) @(negedge clk);
    conv(16'd42, 20'h00042, 5'b11100);

    // Four-digit instance: overflow boundary.
    conv4(16'd10000, 16'h0000, 1'b1, 4'b1110);
    conv4(16'd9999, 16'h9999, 1'b0, 4'b0000);
    conv4(16'd0, 16'h0000, 1'b0, 4'b1110);

`ifdef BCD_SEQ_BLANK_EN
    conv(16'd7, 20'h00007, 5'b11110);
    conv(16'd0, 20'h00000, 5'b11110);
`endif

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("queue4_empty", 32'(q4.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
